// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// fd_entry_t is the common {valid, pc, insn} record used for the F/D latch, skid entry and ROM response.
package fetch_pkg;

   localparam int          FETCH_ADDR_W   = 12;
   localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] FETCH_NOP      = 32'h0000_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] insn;
   } fd_entry_t;

   // Saturating increment for event counters that must never wrap back to zero.
   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer: parks the in-flight ROM response while decode stalls,
// so it can be replayed ahead of the instruction still being read.
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic      clock,
   input  logic      reset,
   input  logic      flush,
   input  logic      stall,
   input  fd_entry_t resp,
   output fd_entry_t hold
);

   // Capture once on the first stalled cycle with a live response; release on the first unstalled edge.
   always_ff @(posedge clock) begin
      if (!reset) begin
         hold <= '0;
      end else if (flush) begin
         hold.valid <= 1'b0;
      end else if (stall) begin
         if (resp.valid && !hold.valid) begin
            hold <= resp;
         end
      end else begin
         hold.valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, synchronous ROM addressing, skid buffer and registered F/D latch.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int          ADDR_W   = FETCH_ADDR_W,
   parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
   parameter logic [31:0] NOP      = FETCH_NOP
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] address_imem,
   input  logic [31:0] q_imem,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        fd_valid,
   output logic [31:0] fd_pc,
`ifdef FETCH_PERF_EN
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flushes,
`endif
   output logic [31:0] fd_insn
);

   logic [ADDR_W-1:0] pc_q;
   logic              resp_valid;
   logic [ADDR_W-1:0] resp_pc;
   fd_entry_t         resp_entry;
   fd_entry_t         hold_entry;
   fd_entry_t         fd_q;
   fd_entry_t         fd_next;
   logic              unused_target_bits;

   assign unused_target_bits = ^redirect_target;

   assign address_imem = 32'(pc_q);
   assign resp_entry   = '{valid: resp_valid, pc: 32'(resp_pc), insn: q_imem};

   fetch_skid_buf u_skid (
      .clock (clock),
      .reset (reset),
      .flush (redirect_valid),
      .stall (stall),
      .resp  (resp_entry),
      .hold  (hold_entry)
   );

   // The parked entry is older than the live response, so it always drains first.
   always_comb begin
      fd_next = resp_entry;
      if (hold_entry.valid) begin
         fd_next = hold_entry;
      end else if (!resp_valid) begin
         fd_next.insn = NOP;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         pc_q       <= RESET_PC[ADDR_W-1:0];
         resp_valid <= 1'b0;
         resp_pc    <= '0;
         fd_q       <= '{valid: 1'b0, pc: 32'd0, insn: NOP};
      end else if (redirect_valid) begin
         pc_q        <= redirect_target[ADDR_W-1:0];
         resp_valid  <= 1'b0;
         fd_q.valid  <= 1'b0;
         fd_q.insn   <= NOP;
      end else if (stall) begin
         // PC is frozen, so the ROM keeps returning insn(pc_q); track it as the live response.
         resp_valid <= 1'b1;
         resp_pc    <= pc_q;
      end else begin
         fd_q       <= fd_next;
         pc_q       <= pc_q + ADDR_W'(1);
         resp_valid <= 1'b1;
         resp_pc    <= pc_q;
      end
   end

   assign fd_valid = fd_q.valid;
   assign fd_pc    = fd_q.pc;
   assign fd_insn  = fd_q.insn;

`ifdef FETCH_PERF_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         perf_fetched      <= 32'd0;
         perf_stall_cycles <= 32'd0;
         perf_flushes      <= 32'd0;
      end else begin
         if (stall) begin
            perf_stall_cycles <= sat_inc(perf_stall_cycles);
         end
         if (redirect_valid) begin
            perf_flushes <= sat_inc(perf_flushes);
         end else if (!stall && fd_next.valid) begin
            perf_fetched <= sat_inc(perf_fetched);
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: start-up, stall/replay, redirects, reset mid-stall,
// and PC wrap on a second ADDR_W=4 instance running alongside.
module tb_fetch_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] address_imem;
   logic [31:0] q_imem;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        fd_valid;
   logic [31:0] fd_pc;
   logic [31:0] fd_insn;

   logic        reset4;
   logic [31:0] address4;
   logic [31:0] q4;
   logic        fd_valid4;
   logic [31:0] fd_pc4;
   logic [31:0] fd_insn4;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_stall_cycles, perf_flushes;
   logic [31:0] perf_fetched4, perf_stall_cycles4, perf_flushes4;
`endif

   int checks_total  = 0;
   int checks_passed = 0;

   always #5 clock = ~clock;

   // ROM image: mem[i] = i + 100, one-cycle read latency.
   always @(posedge clock) begin
      q_imem <= address_imem + 32'd100;
      q4     <= address4 + 32'd100;
   end

   fetch_stage dut (
      .clock           (clock),
      .reset           (reset),
      .address_imem    (address_imem),
      .q_imem          (q_imem),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .fd_valid        (fd_valid),
      .fd_pc           (fd_pc),
`ifdef FETCH_PERF_EN
      .perf_fetched      (perf_fetched),
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flushes      (perf_flushes),
`endif
      .fd_insn         (fd_insn)
   );

   fetch_stage #(.ADDR_W(4)) dut4 (
      .clock           (clock),
      .reset           (reset4),
      .address_imem    (address4),
      .q_imem          (q4),
      .stall           (1'b0),
      .redirect_valid  (1'b0),
      .redirect_target (32'd0),
      .fd_valid        (fd_valid4),
      .fd_pc           (fd_pc4),
`ifdef FETCH_PERF_EN
      .perf_fetched      (perf_fetched4),
      .perf_stall_cycles (perf_stall_cycles4),
      .perf_flushes      (perf_flushes4),
`endif
      .fd_insn         (fd_insn4)
   );

   task automatic applyStimulus(input logic rst, input logic stl, input logic rv, input logic [31:0] rt);
      reset           = rst;
      stall           = stl;
      redirect_valid  = rv;
      redirect_target = rt;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks_total++;
      assert (observed === expected) checks_passed++;
      else $error("[TB] FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, observed, observed, expected, expected);
   endtask

   task automatic checkOutput(input string tag, input logic exp_valid, input logic [31:0] exp_pc,
                              input logic [31:0] exp_insn, input logic check_pc);
      checkValue({tag, ".valid"}, {31'd0, fd_valid}, {31'd0, exp_valid});
      if (check_pc) checkValue({tag, ".pc"}, fd_pc, exp_pc);
      checkValue({tag, ".insn"}, fd_insn, exp_insn);
   endtask

   task automatic checkWrap(input string tag, input logic [31:0] exp_pc);
      checkValue({tag, ".valid"}, {31'd0, fd_valid4}, 32'd1);
      checkValue({tag, ".pc"}, fd_pc4, exp_pc);
      checkValue({tag, ".insn"}, fd_insn4, exp_pc + 32'd100);
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      reset4 = 1'b0;
      step();
      step();
      checkOutput("reset", 1'b0, 32'd0, 32'd0, 1'b1);
      checkValue("reset.addr", address_imem, 32'd0);

      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      reset4 = 1'b1;
      step();                                             // edge 1
      checkOutput("startup.e1", 1'b0, 32'd0, 32'd0, 1'b0);
      step();                                             // edge 2
      checkOutput("startup.e2", 1'b1, 32'd0, 32'd100, 1'b1);
      step();                                             // edge 3
      checkOutput("run.pc1", 1'b1, 32'd1, 32'd101, 1'b1);
      checkValue("run.addr", address_imem, 32'd3);
      step();
      checkOutput("run.pc2", 1'b1, 32'd2, 32'd102, 1'b1);
      step();
      checkOutput("run.pc3", 1'b1, 32'd3, 32'd103, 1'b1);
      step();                                             // edge 6
      checkOutput("run.pc4", 1'b1, 32'd4, 32'd104, 1'b1);

      // Three stalled edges: F/D latch and PC must both freeze.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();                                          // edges 7..9
         checkOutput("stall.hold", 1'b1, 32'd4, 32'd104, 1'b1);
         checkValue("stall.addr", address_imem, 32'd6);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      step();                                             // edge 10
      checkOutput("release.pc5", 1'b1, 32'd5, 32'd105, 1'b1);
      step();
      checkOutput("release.pc6", 1'b1, 32'd6, 32'd106, 1'b1);
      step();                                             // edge 12
      checkOutput("release.pc7", 1'b1, 32'd7, 32'd107, 1'b1);

      // Redirect to 40: two invalid cycles, then the target, and never pc 8 or 9.
      applyStimulus(1'b1, 1'b0, 1'b1, 32'd40);
      step();                                             // edge 13
      checkOutput("redir40.e1", 1'b0, 32'd7, 32'd0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      step();
      checkOutput("redir40.e2", 1'b0, 32'd0, 32'd0, 1'b0);
      step();                                             // edge 15
      checkOutput("redir40.tgt", 1'b1, 32'd40, 32'd140, 1'b1);
      step();                                             // edge 16
      checkOutput("redir40.next", 1'b1, 32'd41, 32'd141, 1'b1);
      checkWrap("wrap.pc14", 32'd14);

      // Redirect to 12 with a simultaneous stall: the redirect takes priority.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'd12);
      step();                                             // edge 17
      checkOutput("redir12.e1", 1'b0, 32'd41, 32'd0, 1'b1);
      checkWrap("wrap.pc15", 32'd15);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      step();
      checkOutput("redir12.e2", 1'b0, 32'd0, 32'd0, 1'b0);
      checkWrap("wrap.pc0", 32'd0);
      step();                                             // edge 19
      checkOutput("redir12.tgt", 1'b1, 32'd12, 32'd112, 1'b1);
      checkWrap("wrap.pc1", 32'd1);
      step();                                             // edge 20
      checkOutput("redir12.next", 1'b1, 32'd13, 32'd113, 1'b1);
`ifdef FETCH_PERF_EN
      checkValue("perf.flushes", perf_flushes, 32'd2);
`endif

      // Reset during a 2-cycle stall discards the parked entry.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      step();                                             // edge 21
      checkOutput("rststall.hold", 1'b1, 32'd13, 32'd113, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      step();                                             // edge 22
      checkOutput("rststall.reset", 1'b0, 32'd0, 32'd0, 1'b1);
      checkValue("rststall.addr", address_imem, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      step();
      checkOutput("restart.e1", 1'b0, 32'd0, 32'd0, 1'b0);
      step();
      checkOutput("restart.pc0", 1'b1, 32'd0, 32'd100, 1'b1);
      step();
      checkOutput("restart.pc1", 1'b1, 32'd1, 32'd101, 1'b1);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
